// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-lite response codes and the channel FSM encodings
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
endpackage

// File: rtl/axi_lite_addr_chk.sv
// axi_lite_addr_chk: maps a byte address onto an array index and its response code
module axi_lite_addr_chk
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_DEPTH = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
  input  logic [AXI_ADDR_WIDTH-1:0]    i_addr,
  output logic [$clog2(MEM_DEPTH)-1:0] o_idx,
  output logic [1:0]                   o_resp
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH:0] SPAN = (AXI_ADDR_WIDTH + 1)'(MEM_DEPTH * (AXI_DATA_WIDTH / 8));
  logic [AXI_ADDR_WIDTH-1:0] w_off;
  logic                      w_hit;
  assign w_off  = i_addr - BASE_ADDR;
  assign w_hit  = (i_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
  assign o_idx  = IDX_W'(w_off >> OFF_W);
  // decode failure outranks misalignment
  assign o_resp = !w_hit ? RESP_DECERR : |i_addr[OFF_W-1:0] ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: rtl/mem_axi_4_lite_sram.sv
// mem_axi_4_lite_sram: AXI4-lite slave over a byte-strobed SRAM array with
// independent read/write channels and configurable response latency
module mem_axi_4_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [2:0]                  AXI_AWPROT,
  input  logic                        AXI_AWVALID,
  output logic                        AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  output logic [1:0]                  AXI_BRESP,
  output logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int RCW = $clog2(RD_LATENCY + 1);
  localparam int WCW = $clog2(WR_LATENCY + 1);

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  r_state_e                  r_rd_state, w_rd_state_nx;
  logic [RCW-1:0]            r_rd_cnt, w_rd_cnt_nx;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp, w_rresp;
  logic [IDX_W-1:0]          w_ridx;
  logic                      w_ar_hs;
  w_state_e                  r_wr_state, w_wr_state_nx;
  logic [WCW-1:0]            r_wr_cnt, w_wr_cnt_nx;
  logic                      r_aw_got, r_w_got;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, w_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [BYTES-1:0]          r_wstrb, w_wstrb;
  logic [1:0]                r_bresp, w_wresp;
  logic [IDX_W-1:0]          w_widx;
  logic                      w_aw_hs, w_w_hs, w_commit, w_unused;

  assign w_unused = ^{AXI_AWPROT, AXI_ARPROT};

  axi_lite_addr_chk #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_rd_chk (.i_addr(AXI_ARADDR), .o_idx(w_ridx), .o_resp(w_rresp));

  axi_lite_addr_chk #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
  ) u_wr_chk (.i_addr(w_awaddr), .o_idx(w_widx), .o_resp(w_wresp));

  assign AXI_ARREADY = r_rd_state == R_IDLE;
  assign AXI_RVALID  = r_rd_state == R_RESP;
  assign AXI_RDATA   = r_rdata;
  assign AXI_RRESP   = r_rresp;
  assign w_ar_hs     = AXI_ARVALID && AXI_ARREADY;

  always_comb begin
    w_rd_state_nx = r_rd_state;
    w_rd_cnt_nx   = r_rd_cnt;
    case (r_rd_state)
      R_IDLE: if (AXI_ARVALID) begin
        w_rd_state_nx = RD_LATENCY == 1 ? R_RESP : R_WAIT;
        w_rd_cnt_nx   = RCW'(RD_LATENCY - 1);
      end
      R_WAIT: begin
        w_rd_cnt_nx = r_rd_cnt - RCW'(1);
        if (r_rd_cnt == RCW'(1)) w_rd_state_nx = R_RESP;
      end
      R_RESP: if (AXI_RREADY) w_rd_state_nx = R_IDLE;
      default: w_rd_state_nx = R_IDLE;
    endcase
  end

  // the array is sampled on the AR edge so a same-edge write commit is not seen
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_nx;
      r_rd_cnt   <= w_rd_cnt_nx;
      if (w_ar_hs) begin
        r_rresp <= w_rresp;
        r_rdata <= w_rresp == RESP_OKAY ? r_mem[w_ridx] : '0;
      end
    end
  end

  assign AXI_AWREADY = r_wr_state == W_IDLE && !r_aw_got;
  assign AXI_WREADY  = r_wr_state == W_IDLE && !r_w_got;
  assign AXI_BVALID  = r_wr_state == W_RESP;
  assign AXI_BRESP   = r_bresp;
  assign w_aw_hs     = AXI_AWVALID && AXI_AWREADY;
  assign w_w_hs      = AXI_WVALID && AXI_WREADY;
  assign w_awaddr    = r_aw_got ? r_awaddr : AXI_AWADDR;
  assign w_wdata     = r_w_got ? r_wdata : AXI_WDATA;
  assign w_wstrb     = r_w_got ? r_wstrb : AXI_WSTRB;
  assign w_commit    = (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

  always_comb begin
    w_wr_state_nx = r_wr_state;
    w_wr_cnt_nx   = r_wr_cnt;
    case (r_wr_state)
      W_IDLE: if (w_commit) begin
        w_wr_state_nx = WR_LATENCY == 1 ? W_RESP : W_WAIT;
        w_wr_cnt_nx   = WCW'(WR_LATENCY - 1);
      end
      W_WAIT: begin
        w_wr_cnt_nx = r_wr_cnt - WCW'(1);
        if (r_wr_cnt == WCW'(1)) w_wr_state_nx = W_RESP;
      end
      W_RESP: if (AXI_BREADY) w_wr_state_nx = W_IDLE;
      default: w_wr_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
      r_aw_got   <= 1'b0;
      r_w_got    <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nx;
      r_wr_cnt   <= w_wr_cnt_nx;
      r_aw_got   <= !w_commit && (r_aw_got || w_aw_hs);
      r_w_got    <= !w_commit && (r_w_got || w_w_hs);
      if (w_aw_hs) r_awaddr <= AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= AXI_WDATA;
        r_wstrb <= AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wresp;
    end
  end

  // array contents survive reset
  always_ff @(posedge AXI_ACLK) begin
    if (w_commit && w_wresp == RESP_OKAY)
      for (int i = 0; i < BYTES; i++)
        if (w_wstrb[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_axi_4_lite_sram.sv
// tb_mem_axi_4_lite_sram: two instances (latency 1/1 and 4/3) driven with directed
// and random traffic, checked against an address-map/array model
module tb_mem_axi_4_lite_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][31:0] awaddr, araddr;
  logic [1:0][2:0]  awprot, arprot;
  logic [1:0][63:0] wdata, rdata;
  logic [1:0][7:0]  wstrb;
  logic [1:0][1:0]  bresp, rresp;
  logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] arvalid, arready, rvalid, rready;
  logic [63:0] mdl [2][1024];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_axi_4_lite_sram #(.RD_LATENCY(g == 0 ? 1 : 4), .WR_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
      .AXI_AWADDR(awaddr[g]), .AXI_AWPROT(awprot[g]), .AXI_AWVALID(awvalid[g]), .AXI_AWREADY(awready[g]),
      .AXI_WDATA(wdata[g]), .AXI_WSTRB(wstrb[g]), .AXI_WVALID(wvalid[g]), .AXI_WREADY(wready[g]),
      .AXI_BRESP(bresp[g]), .AXI_BVALID(bvalid[g]), .AXI_BREADY(bready[g]),
      .AXI_ARADDR(araddr[g]), .AXI_ARPROT(arprot[g]), .AXI_ARVALID(arvalid[g]), .AXI_ARREADY(arready[g]),
      .AXI_RDATA(rdata[g]), .AXI_RRESP(rresp[g]), .AXI_RVALID(rvalid[g]), .AXI_RREADY(rready[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rd_lat(input int d); return d == 0 ? 1 : 4; endfunction
  function automatic int wr_lat(input int d); return d == 0 ? 1 : 3; endfunction

  // window is 1024 words of 8 bytes starting at BASE
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a < BASE || a >= BASE + 32'h2000) return 2'b11;
    return a[2:0] != 3'd0 ? 2'b10 : 2'b00;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic void mdl_wr(input int d, input logic [31:0] a, input logic [63:0] dat, input logic [7:0] st);
    if (resp_of(a) != 2'b00) return;
    for (int i = 0; i < 8; i++)
      if (st[i]) mdl[d][idx_of(a)][8*i +: 8] = dat[8*i +: 8];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return BASE - 32'(8 * $urandom_range(1, 4));
      1: return BASE + 32'h2000 + 32'(8 * $urandom_range(0, 4));
      2: return BASE + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(1, 7));
      default: return BASE + 32'(8 * $urandom_range(0, 7));
    endcase
  endfunction

  task automatic rd(input int d, input logic [31:0] a, input int hold);
    logic [63:0] exp_d;
    logic [1:0] exp_r;
    int n;
    exp_r = resp_of(a);
    exp_d = exp_r == 2'b00 ? mdl[d][idx_of(a)] : 64'h0;
    @(negedge clk);
    araddr[d] = a; arprot[d] = 3'($urandom); arvalid[d] = 1'b1; rready[d] = 1'b0;
    chk("arready_idle", arready[d], 1);
    @(posedge clk); #1 arvalid[d] = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!rvalid[d]) chk("arready_busy", arready[d], 0);
    end while (!rvalid[d] && n < 20);
    chk("rd_latency", n, rd_lat(d));
    chk("rdata", rdata[d], exp_d);
    chk("rresp", rresp[d], exp_r);
    repeat (hold) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid[d], 1);
      chk("rdata_hold", rdata[d], exp_d);
      chk("arready_hold", arready[d], 0);
    end
    rready[d] = 1'b1;
    @(posedge clk); #1 rready[d] = 1'b0;
    @(negedge clk);
    chk("rvalid_clr", rvalid[d], 0);
    chk("arready_back", arready[d], 1);
  endtask

  // wlead: cycles by which W precedes AW (0 = same cycle)
  task automatic wr(input int d, input logic [31:0] a, input logic [63:0] dat, input logic [7:0] st,
                    input int wlead, input int hold);
    logic [1:0] exp_r;
    int n;
    exp_r = resp_of(a);
    @(negedge clk);
    wdata[d] = dat; wstrb[d] = st; wvalid[d] = 1'b1; bready[d] = 1'b0;
    chk("wready_idle", wready[d], 1);
    if (wlead > 0) begin
      @(posedge clk); #1 wvalid[d] = 1'b0;
      repeat (wlead - 1) @(posedge clk);
      @(negedge clk);
      chk("wready_low", wready[d], 0);
      chk("awready_wait", awready[d], 1);
      chk("bvalid_early", bvalid[d], 0);
    end
    awaddr[d] = a; awprot[d] = 3'($urandom); awvalid[d] = 1'b1;
    @(posedge clk); #1 awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    mdl_wr(d, a, dat, st);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!bvalid[d]) chk("awready_busy", awready[d], 0);
    end while (!bvalid[d] && n < 20);
    chk("wr_latency", n, wr_lat(d));
    chk("bresp", bresp[d], exp_r);
    repeat (hold) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid[d], 1);
      chk("bresp_hold", bresp[d], exp_r);
      chk("awready_hold", awready[d], 0);
      chk("wready_hold", wready[d], 0);
    end
    bready[d] = 1'b1;
    @(posedge clk); #1 bready[d] = 1'b0;
    @(negedge clk);
    chk("bvalid_clr", bvalid[d], 0);
    chk("awready_back", awready[d], 1);
    chk("wready_back", wready[d], 1);
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk({tag, "_arready"}, arready[d], 1);
    chk({tag, "_awready"}, awready[d], 1);
    chk({tag, "_wready"}, wready[d], 1);
    chk({tag, "_rvalid"}, rvalid[d], 0);
    chk({tag, "_bvalid"}, bvalid[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk_idle("reset", d);
      chk("reset_rdata", rdata[d], 0);
      chk("reset_rresp", rresp[d], 0);
      chk("reset_bresp", bresp[d], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        wr(d, BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 0);
    wr(0, 32'h8000_0008, 64'h1122334455667788, 8'hFF, 0, 0);
    rd(0, 32'h8000_0008, 0);
    wr(0, 32'h8000_0008, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 2, 0);
    rd(0, 32'h8000_0008, 0);
    chk("strobe_merge", rdata[0], 64'h11223344_BBBBBBBB);
    rd(0, 32'h7FFF_FFF8, 0);
    wr(0, 32'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    rd(0, 32'h8000_0000, 0);
    rd(0, 32'h8000_2000, 0);
    wr(0, 32'h8000_2000, 64'h0123456789ABCDEF, 8'hFF, 1, 0);
    wr(0, 32'h8000_0008, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1, 1);
    rd(0, 32'h8000_0008, 0);
    // AR capture and write commit on the same edge at one index
    wr(0, 32'h8000_0010, 64'h0, 8'hFF, 0, 0);
    @(negedge clk);
    awaddr[0] = 32'h8000_0010; awvalid[0] = 1'b1; wdata[0] = 64'h5; wstrb[0] = 8'hFF; wvalid[0] = 1'b1;
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b0; bready[0] = 1'b0;
    @(posedge clk); #1 awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    @(negedge clk);
    chk("coll_rvalid", rvalid[0], 1);
    chk("coll_old", rdata[0], mdl[0][2]);
    chk("coll_bvalid", bvalid[0], 1);
    mdl_wr(0, 32'h8000_0010, 64'h5, 8'hFF);
    rready[0] = 1'b1; bready[0] = 1'b1;
    @(posedge clk); #1 rready[0] = 1'b0; bready[0] = 1'b0;
    rd(0, 32'h8000_0010, 0);
    // long latencies with back-pressure on both channels at once
    fork
      wr(1, BASE + 32'h8, {$urandom, $urandom}, 8'hFF, 0, 5);
      rd(1, BASE + 32'h10, 5);
    join
    rd(1, BASE + 32'h8, 0);
    // asynchronous reset with the write in W_RESP and the read in R_WAIT
    @(negedge clk);
    awaddr[1] = BASE + 32'h18; wdata[1] = 64'hCAFE_F00D_1234_5678; wstrb[1] = 8'hFF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b0;
    @(posedge clk); #1 awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    mdl_wr(1, BASE + 32'h18, 64'hCAFE_F00D_1234_5678, 8'hFF);
    repeat (3) @(negedge clk);
    chk("pre_rst_bvalid", bvalid[1], 1);
    araddr[1] = BASE; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(posedge clk); #1 arvalid[1] = 1'b0;
    @(negedge clk);
    chk("pre_rst_arready", arready[1], 0);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst", 1);
    @(negedge clk) rst_n = 1'b1;
    rd(1, BASE + 32'h18, 0);
    rd(1, BASE, 0);
    for (int k = 0; k < 40; k++) begin
      int d;
      logic [31:0] a;
      d = $urandom_range(0, 1);
      a = rand_addr();
      if ($urandom_range(0, 1) == 0)
        wr(d, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        rd(d, a, $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_axi_4_lite_sram.md
Name: mem_axi_4_lite_sram

Overview:
AXI4-lite slave memory with an internal byte-strobed SRAM array. Replaces the DPI-backed AXI4-lite memory model so that NPC simulations and FPGA builds can run the same RTL.
- Read and write latency are configurable.
- A mapped address window is enforced.
- Decode and alignment errors are reported on BRESP/RRESP.
- AW and W are accepted independently.

Parameters:
AXI_DATA_WIDTH, 64, data bus width in bits; must be 32 or 64.
AXI_ADDR_WIDTH, 32, address bus width in bits.
MEM_DEPTH, 1024, number of data words in the array; must be a power of 2.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
RD_LATENCY, 1, cycles from AR handshake to RVALID; must be ≥1.
WR_LATENCY, 1, cycles from the completion of both AW and W to BVALID; must be ≥1.

Ports:
AXI_ACLK  in  1  clock; all logic on rising edge.
AXI_ARESETN  in  1  reset, asynchronous, active-low.
AXI_AWADDR  in  AXI_ADDR_WIDTH  write address.
AXI_AWPROT  in  3  ignored.
AXI_AWVALID  in  1  write-address valid.
AXI_AWREADY  out  1  write-address ready.
AXI_WDATA  in  AXI_DATA_WIDTH  write data.
AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte strobes.
AXI_WVALID  in  1  write-data valid.
AXI_WREADY  out  1  write-data ready.
AXI_BRESP  out  2  write response.
AXI_BVALID  out  1  write response valid.
AXI_BREADY  in  1  write response ready.
AXI_ARADDR  in  AXI_ADDR_WIDTH  read address.
AXI_ARPROT  in  3  ignored.
AXI_ARVALID  in  1  read-address valid.
AXI_ARREADY  out  1  read-address ready.
AXI_RDATA  out  AXI_DATA_WIDTH  read data.
AXI_RRESP  out  2  read response.
AXI_RVALID  out  1  read data valid.
AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset values, applied asynchronously while AXI_ARESETN=0:
  - AWREADY=WREADY=ARREADY=1.
  - BVALID=RVALID=0.
  - BRESP=RRESP=2'b00; RDATA=0.
  - Both FSMs go to IDLE; latency counters are cleared.
  - SRAM contents are NOT reset. A reset mid-transaction abandons it; a write already committed stays committed.
- Response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Address check, applied to the captured address:
  - Outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*(AXI_DATA_WIDTH/8)) → DECERR.
  - Otherwise, low log2(AXI_DATA_WIDTH/8) bits non-zero → SLVERR.
  - DECERR has priority over SLVERR.
- Index: (addr-BASE_ADDR) >> log2(bytes), truncated to log2(MEM_DEPTH) bits.
- Read FSM:
  - R_IDLE, ARREADY=1. On ARVALID, capture the address, ARREADY→0, then:
    - RD_LATENCY=1: go to R_RESP.
    - RD_LATENCY>1: go to R_WAIT with the counter loaded to RD_LATENCY-1.
  - R_WAIT: the counter decrements each cycle; at 1, go to R_RESP.
  - Entering R_RESP: RVALID=1 with RDATA and RRESP registered. On error, RDATA=0 and the array is not read.
  - R_RESP: hold RVALID, RDATA and RRESP stable until RREADY. On the handshake edge: RVALID→0, ARREADY→1, go to R_IDLE. No back-to-back AR is accepted on the R handshake edge.
  - The first RVALID occurs exactly RD_LATENCY cycles after the AR handshake edge.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE:
    - AW and W are captured independently. Each ready drops on its own handshake and stays low until the B handshake.
    - Once both are captured (same edge or different edges), the array is written on that edge for every byte with WSTRB[i]=1, only when the response is OKAY.
    - Then go to W_WAIT, or straight to W_RESP when WR_LATENCY=1.
  - Entering W_RESP: BVALID=1 with BRESP.
  - W_RESP: hold until BREADY; on the handshake edge BVALID→0, AWREADY=WREADY→1, go to W_IDLE.
  - BVALID occurs WR_LATENCY cycles after the edge on which the second of AW/W was captured.
- WSTRB=0 with a valid address: no byte changes, BRESP=OKAY.
- Read/write collision: if the AR capture and the write commit happen on the same edge at the same index, the read returns the pre-write data.
- The read and write channels are fully independent and may both be busy concurrently.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY, RESP_EXOKAY (2'b01), RESP_SLVERR, RESP_DECERR localparams.
  - Read FSM encodings R_IDLE, R_WAIT, R_RESP.
  - Write FSM encodings W_IDLE, W_WAIT, W_RESP.
- One combinational sub-module, axi_lite_addr_chk (parameters BASE_ADDR, MEM_DEPTH, AXI_DATA_WIDTH, AXI_ADDR_WIDTH): address in, index and resp out. It is instantiated twice, once for read and once for write.

Test Plan:
- Write: AW 0x8000_0008, WDATA 64'h1122334455667788, WSTRB 8'hFF, same cycle; then read 0x8000_0008 with RD_LATENCY=1 → BRESP=00, RDATA=64'h1122334455667788, RRESP=00, RVALID exactly 1 cycle after AR.
- WSTRB 8'h0F writing 64'hAAAAAAAA_BBBBBBBB over the previous word → readback 64'h11223344_BBBBBBBB. W two cycles before AW → BVALID 1 cycle after the AW edge.
- Read 0x7FFF_FFF8 → RRESP=11, RDATA=0. Write 0x8000_0004 → BRESP=10 and memory unchanged. Address 0x8000_2000 with depth 1024×8 → DECERR.
- RD_LATENCY=4, WR_LATENCY=3, RREADY/BREADY held low 5 cycles → RVALID at +4 and BVALID at +3, both stable until ready; ARREADY/AWREADY low throughout.
- Same-edge AR and write commit at 0x8000_0010 (old 0, new 64'h5) → read returns 0; a subsequent read returns 5.
- AXI_ARESETN pulled low asynchronously while in R_WAIT and W_RESP → RVALID=BVALID=0 immediately and all readies=1; after release, earlier committed data is still readable.
